router_pkt_fifo: RTL
====================

ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data byte width (>=4).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning storage words (power of 2, >=4).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full threshold in words.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1, the single clock (rising edge).
REQ-006 The block SHALL have port resetn, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port soft_reset, input, 1, synchronous flush.
REQ-008 The block SHALL have port write_enb, input, 1, write request.
REQ-009 The block SHALL have port lfd_state, input, 1, marking the current write as a packet header.
REQ-010 The block SHALL have port datain, input, DATA_W, write data.
REQ-011 The block SHALL have port read_enb, input, 1, read request.
REQ-012 The block SHALL have port dataout, output, DATA_W, registered read data.
REQ-013 The block SHALL have port dout_valid, output, 1, dataout holds a word read the previous cycle.
REQ-014 The block SHALL have port pkt_done, output, 1, one-cycle pulse alongside the last word of a packet.
REQ-015 The block SHALL have port full, output, 1, count==DEPTH.
REQ-016 The block SHALL have port empty, output, 1, count==0.
REQ-017 The block SHALL have port almost_full, output, 1, count>=AF_LEVEL.
REQ-018 The block SHALL have port err_ovf, output, 1, sticky: write attempted while full.
REQ-019 The block SHALL have port err_udf, output, 1, sticky: read attempted while empty.

Function
REQ-020 Each entry SHALL store {hdr_tag, data}, with hdr_tag = lfd_state sampled in the same cycle as the write.
REQ-021 A write SHALL be accepted when write_enb && !full, using flag values from the start of that cycle; the write pointer SHALL wrap modulo DEPTH.
REQ-022 A read SHALL be accepted when read_enb && !empty; dataout SHALL update one cycle later with dout_valid=1, otherwise dout_valid=0 and dataout holds.
REQ-023 The occupancy counter SHALL be $clog2(DEPTH)+1 bits; a simultaneous accepted read and write leaves it unchanged, and with full && both requests only the read is accepted.
REQ-024 full, empty and almost_full SHALL be decoded combinationally from the registered count.
REQ-025 Reading a word with hdr_tag=1 SHALL load remaining = data[DATA_W-1:2] + 1 (payload plus parity).
REQ-026 Each later accepted read SHALL decrement remaining while it is nonzero.
REQ-027 pkt_done SHALL pulse with dout_valid when the read word took remaining from 1 to 0.
REQ-028 A header read while remaining!=0 SHALL reload remaining, with no pkt_done for the truncated packet.

Reset
REQ-029 resetn low SHALL asynchronously clear the pointers, count, remaining, dataout=0, dout_valid=0, pkt_done=0, err_ovf=0 and err_udf=0; storage SHALL NOT be reset.
REQ-030 soft_reset SHALL synchronously apply the same clears, take priority over a same-cycle read/write, and also clear the err flags.

Configuration
REQ-031 With ROUTER_FIFO_ERR_EN defined, err_ovf/err_udf SHALL set as in REQ-018/019; without it they SHALL be tied 0 and no error logic synthesised.

Structure
REQ-032 Package router_pkg SHALL hold the header length-field bounds (LEN_MSB=DATA_W-1, LEN_LSB=2) and a fifo-entry struct type.
REQ-033 Storage SHALL be a sub-module router_fifo_mem: one write port, one registered read port, no reset.

Verification
REQ-034 After reset, write 16 words with no reads -> full=1 at count 16, almost_full from count 14, and a 17th write is dropped (err_ovf=1 if ERR_EN).
REQ-035 Write header 0x0C (length 3) + 3 payload + 1 parity, then read continuously -> 5 dout_valid cycles, pkt_done on the 5th word only.
REQ-036 At count 8, read_enb and write_enb together for 20 cycles -> count stays 8, data in order, pointers wrap without loss.
REQ-037 Read while empty -> dout_valid=0, dataout unchanged, err_udf=1 (0 without ERR_EN).
REQ-038 soft_reset asserted mid-packet together with write_enb -> next cycle empty=1, count=0, dataout=0, write discarded.
REQ-039 resetn asserted between clock edges -> outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router packet FIFO: header length-field bounds
// and the stored entry layout (header tag bit above the data byte).
package router_pkg;

  localparam int PKG_DATA_W = 8;
  localparam int LEN_MSB    = PKG_DATA_W - 1;
  localparam int LEN_LSB    = 2;

  typedef struct packed {
    logic                  hdrTag;
    logic [PKG_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Packet FIFO storage: one write port and one registered read port.
// The array and the read register are deliberately not reset.
module router_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/router_pkt_fifo.sv
// Router packet FIFO: tagged header/data storage with packet-length tracking.
// Define ROUTER_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] datain,
  input  logic              read_enb,
  output logic [DATA_W-1:0] dataout,
  output logic              dout_valid,
  output logic              pkt_done,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = DATA_W - LEN_LSB + 1;

  logic [AW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [RW-1:0]   remaining_q, remaining_d;
  logic            doutValid_q, doutValid_d;
  logic            stale_q, stale_d;
  logic            wrAcc, rdAcc;
  logic [DATA_W:0] memRdata;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AF_LEVEL));

  assign wrAcc = write_enb && !full && !soft_reset;
  assign rdAcc = read_enb && !empty && !soft_reset;

  router_fifo_mem #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wrAcc),
    .waddr (wrPtr_q),
    .wdata ({lfd_state, datain}),
    .re    (rdAcc),
    .raddr (rdPtr_q),
    .rdata (memRdata)
  );

  // The memory read register has no reset, so stale_q masks it to zero
  // after any reset until the next accepted read lands.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    doutValid_d = 1'b0;
    stale_d     = stale_q;
    if (soft_reset) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      remaining_d = '0;
      stale_d     = 1'b1;
    end else begin
      if (wrAcc) wrPtr_d = wrPtr_q + AW'(1);
      if (rdAcc) begin
        rdPtr_d     = rdPtr_q + AW'(1);
        doutValid_d = 1'b1;
        stale_d     = 1'b0;
      end
      case ({wrAcc, rdAcc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // Packet length is tracked as each word emerges on dataout.
      if (doutValid_q) begin
        if (memRdata[DATA_W])
          remaining_d = {1'b0, memRdata[DATA_W-1:LEN_LSB]} + RW'(1);
        else if (remaining_q != '0)
          remaining_d = remaining_q - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      doutValid_q <= 1'b0;
      stale_q     <= 1'b1;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      doutValid_q <= doutValid_d;
      stale_q     <= stale_d;
    end
  end

  assign dataout    = stale_q ? '0 : memRdata[DATA_W-1:0];
  assign dout_valid = doutValid_q;
  assign pkt_done   = doutValid_q && !memRdata[DATA_W] && (remaining_q == RW'(1));

`ifdef ROUTER_FIFO_ERR_EN
  logic errOvf_q, errOvf_d, errUdf_q, errUdf_d;

  always_comb begin
    errOvf_d = errOvf_q;
    errUdf_d = errUdf_q;
    if (soft_reset) begin
      errOvf_d = 1'b0;
      errUdf_d = 1'b0;
    end else begin
      if (write_enb && full) errOvf_d = 1'b1;
      if (read_enb && empty) errUdf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      errOvf_q <= 1'b0;
      errUdf_q <= 1'b0;
    end else begin
      errOvf_q <= errOvf_d;
      errUdf_q <= errUdf_d;
    end
  end

  assign err_ovf = errOvf_q;
  assign err_udf = errUdf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule
